// File: rtl/exp_sp_pkg.sv
// Shared definitions for the exp/softplus request scheduler.
//   DW_DEF          default operand/result width
//   REQ_DEPTH_DEF   default request FIFO depth
//   RSP_DEPTH_DEF   default response FIFO depth (also per-mode credit count)
//   mode_e          mode encoding, SP = 1, EXP = 0
package exp_sp_pkg;
    localparam int DW_DEF        = 16;
    localparam int REQ_DEPTH_DEF = 4;
    localparam int RSP_DEPTH_DEF = 8;

    typedef enum logic {
        MODE_EXP = 1'b0,
        MODE_SP  = 1'b1
    } mode_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. dout is the head entry whenever empty is low.
// Ports:
//   clk, rstn        clock, synchronous active-low reset (empties the FIFO)
//   push, din        write request / data; dropped if full and not popping
//   pop              read request; ignored while empty
//   dout             head entry (show-ahead)
//   full, empty      occupancy flags
//   count            number of stored entries
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo #(
    parameter  int DW    = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so push on full is accepted then.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/exp_sp_req_sched.sv
// Initiator-side scheduler for the shared exp/softplus core.
// Buffers independent SP and EXP operand streams, issues at most one request
// per cycle to the core (round-robin when both are ready), and gathers the
// core results into per-mode output FIFOs. The core cannot stall, so each mode
// only issues while it holds a credit, i.e. guaranteed space in its response
// FIFO.
// Ports:
//   clk, rstn                         clock, synchronous active-low reset
//   sp_in_v/rdy/x, exp_in_v/rdy/x     operand streams (valid/ready)
//   sp_req_v/sp_x, exp_req_v/exp_x    registered requests to the core
//   sp_rsp_v/sp_y, exp_rsp_v/exp_y    core results (no backpressure)
//   sp_out_v/rdy/y, exp_out_v/rdy/y   result streams (valid/ready, show-ahead)
// Optional (EXP_SP_SCHED_STATS_EN): stat_sp_issue, stat_exp_issue, stat_stall,
// saturating 32-bit counters of grants per mode and credit-stalled cycles.
module exp_sp_req_sched
    import exp_sp_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int REQ_DEPTH = REQ_DEPTH_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sp_in_v,
    output logic          sp_in_rdy,
    input  logic [DW-1:0] sp_in_x,
    input  logic          exp_in_v,
    output logic          exp_in_rdy,
    input  logic [DW-1:0] exp_in_x,
    output logic          sp_req_v,
    output logic [DW-1:0] sp_x,
    output logic          exp_req_v,
    output logic [DW-1:0] exp_x,
    input  logic          sp_rsp_v,
    input  logic [DW-1:0] sp_y,
    input  logic          exp_rsp_v,
    input  logic [DW-1:0] exp_y,
    output logic          sp_out_v,
    input  logic          sp_out_rdy,
    output logic [DW-1:0] sp_out_y,
    output logic          exp_out_v,
    input  logic          exp_out_rdy,
    output logic [DW-1:0] exp_out_y
`ifdef EXP_SP_SCHED_STATS_EN
    ,
    output logic [31:0]   stat_sp_issue,
    output logic [31:0]   stat_exp_issue,
    output logic [31:0]   stat_stall
`endif
);
    localparam int CRW  = $clog2(RSP_DEPTH + 1);
    localparam int RQCW = $clog2(REQ_DEPTH + 1);
    localparam int RSCW = $clog2(RSP_DEPTH + 1);

    logic            sp_rq_full, sp_rq_empty, exp_rq_full, exp_rq_empty;
    logic [DW-1:0]   sp_rq_head, exp_rq_head;
    logic            sp_rs_full, sp_rs_empty, exp_rs_full, exp_rs_empty;
    logic [RQCW-1:0] sp_rq_lvl, exp_rq_lvl;
    logic [RSCW-1:0] sp_rs_lvl, exp_rs_lvl;
    logic [CRW-1:0]  sp_cred, exp_cred;
    mode_e           last_gnt;
    logic            sp_elig, exp_elig, sp_gnt, exp_gnt, sp_pop, exp_pop;

    // FIFO levels and response-full flags are only of interest to the sim checks.
    logic unused_sigs;
    assign unused_sigs = ^{sp_rq_lvl, exp_rq_lvl, sp_rs_lvl, exp_rs_lvl, sp_rs_full, exp_rs_full};

    assign sp_in_rdy  = rstn & ~sp_rq_full;
    assign exp_in_rdy = rstn & ~exp_rq_full;
    assign sp_out_v   = rstn & ~sp_rs_empty;
    assign exp_out_v  = rstn & ~exp_rs_empty;
    assign sp_pop     = sp_out_v & sp_out_rdy;
    assign exp_pop    = exp_out_v & exp_out_rdy;

    assign sp_elig  = ~sp_rq_empty  & (sp_cred  != '0);
    assign exp_elig = ~exp_rq_empty & (exp_cred != '0);

    // Round-robin between the two modes: on contention the mode not granted
    // last wins; last_gnt resets to EXP so SP wins the first tie.
    always_comb begin
        sp_gnt  = sp_elig & (~exp_elig | (last_gnt == MODE_EXP));
        exp_gnt = exp_elig & ~sp_gnt;
    end

    sync_fifo #(.DW(DW), .DEPTH(REQ_DEPTH)) u_sp_rq (
        .clk(clk), .rstn(rstn), .push(sp_in_v & sp_in_rdy), .din(sp_in_x), .pop(sp_gnt),
        .dout(sp_rq_head), .full(sp_rq_full), .empty(sp_rq_empty), .count(sp_rq_lvl));

    sync_fifo #(.DW(DW), .DEPTH(REQ_DEPTH)) u_exp_rq (
        .clk(clk), .rstn(rstn), .push(exp_in_v & exp_in_rdy), .din(exp_in_x), .pop(exp_gnt),
        .dout(exp_rq_head), .full(exp_rq_full), .empty(exp_rq_empty), .count(exp_rq_lvl));

    // Responses are pushed unconditionally; credits guarantee a free slot.
    sync_fifo #(.DW(DW), .DEPTH(RSP_DEPTH)) u_sp_rs (
        .clk(clk), .rstn(rstn), .push(sp_rsp_v), .din(sp_y), .pop(sp_pop),
        .dout(sp_out_y), .full(sp_rs_full), .empty(sp_rs_empty), .count(sp_rs_lvl));

    sync_fifo #(.DW(DW), .DEPTH(RSP_DEPTH)) u_exp_rs (
        .clk(clk), .rstn(rstn), .push(exp_rsp_v), .din(exp_y), .pop(exp_pop),
        .dout(exp_out_y), .full(exp_rs_full), .empty(exp_rs_empty), .count(exp_rs_lvl));

    // Issue stage and credits. A credit is taken at grant and returned when the
    // consumer takes the result, so credit + in-flight + stored == RSP_DEPTH.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sp_cred   <= CRW'(RSP_DEPTH);
            exp_cred  <= CRW'(RSP_DEPTH);
            last_gnt  <= MODE_EXP;
            sp_req_v  <= 1'b0;
            exp_req_v <= 1'b0;
            sp_x      <= '0;
            exp_x     <= '0;
        end else begin
            sp_cred  <= sp_cred  - CRW'(sp_gnt)  + CRW'(sp_pop);
            exp_cred <= exp_cred - CRW'(exp_gnt) + CRW'(exp_pop);
            if (sp_gnt)       last_gnt <= MODE_SP;
            else if (exp_gnt) last_gnt <= MODE_EXP;
            sp_req_v  <= sp_gnt;
            exp_req_v <= exp_gnt;
            sp_x      <= sp_gnt  ? sp_rq_head  : '0;
            exp_x     <= exp_gnt ? exp_rq_head : '0;
        end
    end

`ifdef EXP_SP_SCHED_STATS_EN
    logic stall;
    assign stall = (~sp_rq_empty & (sp_cred == '0)) | (~exp_rq_empty & (exp_cred == '0));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_sp_issue  <= '0;
            stat_exp_issue <= '0;
            stat_stall     <= '0;
        end else begin
            if (sp_gnt  && stat_sp_issue  != '1) stat_sp_issue  <= stat_sp_issue  + 32'd1;
            if (exp_gnt && stat_exp_issue != '1) stat_exp_issue <= stat_exp_issue + 32'd1;
            if (stall   && stat_stall     != '1) stat_stall     <= stat_stall     + 32'd1;
        end
    end
`endif

`ifdef SIM
    always @(posedge clk) begin
        if (rstn) begin
            assert (!(sp_req_v && exp_req_v))
                else $error("sp_req_v and exp_req_v both high");
            assert (!(sp_rsp_v && sp_rs_full && !sp_pop))
                else $error("SP response pushed into full FIFO");
            assert (!(exp_rsp_v && exp_rs_full && !exp_pop))
                else $error("EXP response pushed into full FIFO");
            assert (!(sp_rsp_v && sp_cred == CRW'(RSP_DEPTH) && sp_rs_empty))
                else $error("unsolicited SP response");
            assert (!(exp_rsp_v && exp_cred == CRW'(RSP_DEPTH) && exp_rs_empty))
                else $error("unsolicited EXP response");
        end
    end
`endif
endmodule

// File: tb/tb_exp_sp_req_sched.sv
module tb_exp_sp_req_sched;
    localparam int DW  = 16;
    localparam int RD  = 8;
    localparam int LAT = 12;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic          sp_in_v, sp_in_rdy, exp_in_v, exp_in_rdy;
    logic [DW-1:0] sp_in_x, exp_in_x;
    logic          sp_req_v, exp_req_v, sp_rsp_v, exp_rsp_v;
    logic [DW-1:0] sp_x, exp_x, sp_y, exp_y;
    logic          sp_out_v, sp_out_rdy, exp_out_v, exp_out_rdy;
    logic [DW-1:0] sp_out_y, exp_out_y;

    exp_sp_req_sched #(.DW(DW), .REQ_DEPTH(4), .RSP_DEPTH(RD)) dut (
        .clk(clk), .rstn(rstn),
        .sp_in_v(sp_in_v), .sp_in_rdy(sp_in_rdy), .sp_in_x(sp_in_x),
        .exp_in_v(exp_in_v), .exp_in_rdy(exp_in_rdy), .exp_in_x(exp_in_x),
        .sp_req_v(sp_req_v), .sp_x(sp_x), .exp_req_v(exp_req_v), .exp_x(exp_x),
        .sp_rsp_v(sp_rsp_v), .sp_y(sp_y), .exp_rsp_v(exp_rsp_v), .exp_y(exp_y),
        .sp_out_v(sp_out_v), .sp_out_rdy(sp_out_rdy), .sp_out_y(sp_out_y),
        .exp_out_v(exp_out_v), .exp_out_rdy(exp_out_rdy), .exp_out_y(exp_out_y));

    // Stand-in core functions: any distinct mapping per mode will do.
    function automatic logic [DW-1:0] f_sp(input logic [DW-1:0] x);
        return x + 16'h1111;
    endfunction
    function automatic logic [DW-1:0] f_exp(input logic [DW-1:0] x);
        return ~x;
    endfunction

    // Core model: fixed latency, no backpressure, cleared by the shared reset.
    logic          cv_sp [LAT];
    logic          cv_exp[LAT];
    logic [DW-1:0] cx_sp [LAT];
    logic [DW-1:0] cx_exp[LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            cv_sp[i]  <= cv_sp[i-1];  cx_sp[i]  <= cx_sp[i-1];
            cv_exp[i] <= cv_exp[i-1]; cx_exp[i] <= cx_exp[i-1];
        end
        cv_sp[0]  <= rstn & sp_req_v;  cx_sp[0]  <= sp_x;
        cv_exp[0] <= rstn & exp_req_v; cx_exp[0] <= exp_x;
        if (!rstn) for (int i = 0; i < LAT; i++) begin cv_sp[i] <= 1'b0; cv_exp[i] <= 1'b0; end
    end
    assign sp_rsp_v  = cv_sp[LAT-1];
    assign sp_y      = f_sp(cx_sp[LAT-1]);
    assign exp_rsp_v = cv_exp[LAT-1];
    assign exp_y     = f_exp(cx_exp[LAT-1]);

    int vec = 0, err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vec++;
        if (act !== want) begin
            err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, want, $time);
        end
    endtask

    // Reference model: expected results per mode, in acceptance order.
    logic [DW-1:0] q_sp[$], q_exp[$];
    int  iss_sp, iss_exp, res_sp, res_exp; // window counters, cleared by the test
    int  osp, oexp;                         // issued but not yet consumed
    int  sp_todo, exp_todo;                 // operands still to be accepted
    bit  hs_sp, hs_exp, alt_chk, prev_sp, prev_exp;
    int  alt_bad;
    bit  drv_en, rnd_rdy;
    int  gap;

    always @(negedge clk) begin
        hs_sp = 1'b0; hs_exp = 1'b0;
        if (!rstn) begin
            q_sp.delete(); q_exp.delete();
            osp = 0; oexp = 0; prev_sp = 1'b0; prev_exp = 1'b0;
        end else begin
            if (sp_in_v && sp_in_rdy) begin
                q_sp.push_back(f_sp(sp_in_x)); hs_sp = 1'b1; if (sp_todo > 0) sp_todo--;
            end
            if (exp_in_v && exp_in_rdy) begin
                q_exp.push_back(f_exp(exp_in_x)); hs_exp = 1'b1; if (exp_todo > 0) exp_todo--;
            end
            chk("req_exclusive", 32'(!(sp_req_v && exp_req_v)), 1);
            if (!sp_req_v)  chk("sp_x_idle", 32'(sp_x), 0);
            if (!exp_req_v) chk("exp_x_idle", 32'(exp_x), 0);
            if (sp_req_v)  begin iss_sp++;  osp++;  chk("sp_outstanding",  32'(osp <= RD), 1); end
            if (exp_req_v) begin iss_exp++; oexp++; chk("exp_outstanding", 32'(oexp <= RD), 1); end
            if (alt_chk && ((sp_req_v && prev_sp) || (exp_req_v && prev_exp))) alt_bad++;
            prev_sp = sp_req_v; prev_exp = exp_req_v;
            if (sp_out_v && sp_out_rdy) begin
                res_sp++; osp--;
                if (q_sp.size() == 0) chk("sp_unexpected", 1, 0);
                else chk("sp_out_y", 32'(sp_out_y), 32'(q_sp.pop_front()));
            end
            if (exp_out_v && exp_out_rdy) begin
                res_exp++; oexp--;
                if (q_exp.size() == 0) chk("exp_unexpected", 1, 0);
                else chk("exp_out_y", 32'(exp_out_y), 32'(q_exp.pop_front()));
            end
        end
    end

    // Stream driver: holds an offered operand until accepted.
    initial forever begin
        @(posedge clk); #1;
        if (drv_en) begin
            if (!sp_in_v || hs_sp) begin
                sp_in_v = (sp_todo > 0) && ($urandom_range(99) >= gap);
                sp_in_x = 16'($urandom);
            end
            if (!exp_in_v || hs_exp) begin
                exp_in_v = (exp_todo > 0) && ($urandom_range(99) >= gap);
                exp_in_x = 16'($urandom);
            end
        end
        if (rnd_rdy) begin
            sp_out_rdy  = 1'($urandom_range(1));
            exp_out_rdy = 1'($urandom_range(1));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int t = 0;
        rnd_rdy = 1'b0; sp_out_rdy = 1'b1; exp_out_rdy = 1'b1;
        while ((sp_todo > 0 || exp_todo > 0 || q_sp.size() > 0 || q_exp.size() > 0) && t < 3000) begin
            cyc(1); t++;
        end
        chk("drain_in_time", 32'(t < 3000), 1);
        cyc(3);
        chk("drain_sp_idle", 32'(osp), 0);
        chk("drain_exp_idle", 32'(oexp), 0);
    endtask

    typedef struct {
        string name;
        int    n_sp, n_exp;
        bit    sp_rdy, exp_rdy, alt;
        int    cycles;
        int    e_sp_iss, e_exp_iss, e_sp_res, e_exp_res;
    } vec_t;

    task automatic run_vec(input vec_t v);
        drv_en = 1'b1; gap = 0; rnd_rdy = 1'b0;
        sp_out_rdy = v.sp_rdy; exp_out_rdy = v.exp_rdy;
        iss_sp = 0; iss_exp = 0; res_sp = 0; res_exp = 0;
        alt_bad = 0; alt_chk = v.alt;
        sp_todo = v.n_sp; exp_todo = v.n_exp;
        cyc(v.cycles);
        alt_chk = 1'b0;
        chk({v.name, " sp_issued"},  32'(iss_sp),  32'(v.e_sp_iss));
        chk({v.name, " exp_issued"}, 32'(iss_exp), 32'(v.e_exp_iss));
        chk({v.name, " sp_results"}, 32'(res_sp),  32'(v.e_sp_res));
        chk({v.name, " exp_results"},32'(res_exp), 32'(v.e_exp_res));
        if (v.alt) chk({v.name, " alternation"}, 32'(alt_bad), 0);
        drain();
    endtask

    vec_t tbl[4];

    initial begin
        // Credits cap a blocked mode at RD issues; the other mode is unaffected.
        tbl[0] = '{"sp_only",     10, 0,  1, 1, 0, 60, 10, 0, 10, 0};
        tbl[1] = '{"both_sat",     8, 8,  1, 1, 1, 60,  8, 8,  8, 8};
        tbl[2] = '{"sp_blocked",  20, 8,  0, 1, 0, 80, RD, 8,  0, 8};
        tbl[3] = '{"exp_blocked",  6, 12, 1, 0, 0, 80,  6, RD, 6, 0};

        rstn = 1'b0; sp_in_v = 1'b0; exp_in_v = 1'b0; sp_in_x = '0; exp_in_x = '0;
        sp_out_rdy = 1'b0; exp_out_rdy = 1'b0;
        sp_todo = 0; exp_todo = 0; drv_en = 1'b0; rnd_rdy = 1'b0; gap = 0;
        alt_chk = 1'b0; alt_bad = 0;
        cyc(3);
        chk("rst_sp_in_rdy", 32'(sp_in_rdy), 0);
        chk("rst_exp_in_rdy", 32'(exp_in_rdy), 0);
        rstn = 1'b1;
        cyc(3);
        chk("init_sp_out_v", 32'(sp_out_v), 0);
        chk("init_exp_out_v", 32'(exp_out_v), 0);
        chk("init_sp_in_rdy", 32'(sp_in_rdy), 1);
        chk("init_exp_in_rdy", 32'(exp_in_rdy), 1);
        chk("init_req_v", 32'({sp_req_v, exp_req_v}), 0);

        for (int i = 0; i < 4; i++) run_vec(tbl[i]);

        // Freeing one slot of a full EXP response FIFO with zero credit, while
        // an operand is accepted, returns one credit and grants EXP next cycle.
        drv_en = 1'b1; sp_out_rdy = 1'b1; exp_out_rdy = 1'b0; iss_exp = 0; exp_todo = 11;
        cyc(50);
        chk("t5_exp_issued", 32'(iss_exp), RD);
        chk("t5_in_rdy", 32'(exp_in_rdy), 1);
        chk("t5_out_v", 32'(exp_out_v), 1);
        drv_en = 1'b0; exp_in_v = 1'b1; exp_in_x = 16'h1234; exp_out_rdy = 1'b1;
        @(negedge clk);
        chk("t5_both_handshake", 32'(exp_in_rdy & exp_out_v), 1);
        @(posedge clk); #2;
        exp_in_v = 1'b0; exp_out_rdy = 1'b0;
        @(negedge clk); chk("t5_grant_pending", 32'(exp_req_v), 0);
        @(negedge clk); chk("t5_grant", 32'(exp_req_v), 1);
        @(negedge clk); chk("t5_single_credit", 32'(exp_req_v), 0);
        drain();

        // Reset mid-burst with SP requests in flight.
        drv_en = 1'b1; sp_out_rdy = 1'b1; exp_out_rdy = 1'b1; iss_sp = 0; sp_todo = 8;
        begin
            int t = 0;
            while (iss_sp < 5 && t < 200) begin @(negedge clk); t++; end
            chk("t6_burst_started", 32'(t < 200), 1);
        end
        @(posedge clk); #2;
        rstn = 1'b0; drv_en = 1'b0; sp_in_v = 1'b0; exp_in_v = 1'b0; sp_todo = 0; exp_todo = 0;
        @(negedge clk);
        chk("t6_rst_in_rdy", 32'(sp_in_rdy), 0);
        chk("t6_rst_out_v", 32'(sp_out_v), 0);
        @(posedge clk); #2;
        rstn = 1'b1;
        @(negedge clk);
        chk("t6_req_cleared", 32'({sp_req_v, exp_req_v}), 0);
        chk("t6_sp_x_cleared", 32'(sp_x), 0);
        chk("t6_in_rdy", 32'(sp_in_rdy), 1);
        res_sp = 0;
        cyc(20);
        chk("t6_no_stale", 32'(res_sp), 0);
        chk("t6_no_out_v", 32'(sp_out_v), 0);
        sp_in_v = 1'b1; sp_in_x = 16'h3C00;
        @(negedge clk); chk("t6_accept", 32'(sp_in_rdy), 1);
        @(posedge clk); #2;
        sp_in_v = 1'b0;
        @(negedge clk); chk("t6_lat_n1", 32'(sp_req_v), 0);
        @(negedge clk); chk("t6_lat_n2", 32'(sp_req_v), 1);
        chk("t6_operand", 32'(sp_x), 32'h3C00);
        drain();
        chk("t6_one_result", 32'(res_sp), 1);
        run_vec('{"post_rst_cred", 12, 0, 0, 1, 0, 60, RD, 0, 0, 0});

        // Randomized traffic with random gaps and consumer stalls.
        drv_en = 1'b1; gap = 30; rnd_rdy = 1'b1; sp_todo = 150; exp_todo = 150;
        cyc(400);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", err);
        $fatal(1);
    end
endmodule
